// File: rtl/blkmov_engine.sv
// Sequential block-move engine: moves up to MAX_WORDS words between the register
// file and memory, ascending or descending, tolerating memory stalls.
module blkmov_engine #(
  parameter  int WORD_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int NUM_REGS   = 16,
  parameter  int MAX_WORDS  = 8,
  localparam int REG_W      = $clog2(NUM_REGS),
  localparam int CNT_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_store,
  input  logic                  decrement,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [REG_W-1:0]      first_reg,
  input  logic [CNT_W-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] final_ptr,
  output logic [REG_W-1:0]      reg_rd_idx,
  input  logic [WORD_WIDTH-1:0] reg_rd_data,
  output logic                  reg_wr_en,
  output logic [REG_W-1:0]      reg_wr_idx,
  output logic [WORD_WIDTH-1:0] reg_wr_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORD_WIDTH / 8);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  state_t                state_r;
  logic                  dec_r;
  logic [CNT_W-1:0]      n_r;
  logic [CNT_W-1:0]      k_r;
  logic                  busy_r;
  logic                  done_r;
  logic [ADDR_WIDTH-1:0] final_ptr_r;
  logic [REG_W-1:0]      reg_rd_idx_r;
  logic                  reg_wr_en_r;
  logic [REG_W-1:0]      reg_wr_idx_r;
  logic [WORD_WIDTH-1:0] reg_wr_data_r;
  logic                  mem_req_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [CNT_W-1:0]      n_eff_s;

  // Saturate the requested word count at MAX_WORDS
  always_comb begin
    n_eff_s = count;
    if (count > CNT_W'(MAX_WORDS)) begin
      n_eff_s = CNT_W'(MAX_WORDS);
    end else begin
      n_eff_s = count;
    end
  end

  // Control FSM; address and register index advance incrementally per acked word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      dec_r         <= 1'b0;
      n_r           <= '0;
      k_r           <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      final_ptr_r   <= '0;
      reg_rd_idx_r  <= '0;
      reg_wr_en_r   <= 1'b0;
      reg_wr_idx_r  <= '0;
      reg_wr_data_r <= '0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= '0;
    end else begin
      reg_wr_en_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            dec_r  <= decrement;
            n_r    <= n_eff_s;
            k_r    <= '0;
            busy_r <= 1'b1;
            if (n_eff_s == CNT_W'(0)) begin
              state_r     <= DONE;
              done_r      <= 1'b1;
              final_ptr_r <= base_addr;
            end else begin
              state_r      <= XFER;
              mem_req_r    <= 1'b1;
              mem_we_r     <= is_store;
              mem_addr_r   <= decrement ? (base_addr - STEP) : base_addr;
              // Descending starts at the highest register so the lowest lands lowest
              reg_rd_idx_r <= decrement ? (first_reg + REG_W'(n_eff_s - CNT_W'(1))) : first_reg;
            end
          end
        end
        XFER: begin
          if (mem_ack) begin
            if (!mem_we_r) begin
              reg_wr_en_r   <= 1'b1;
              reg_wr_idx_r  <= reg_rd_idx_r;
              reg_wr_data_r <= mem_rdata;
            end
            if (k_r == (n_r - CNT_W'(1))) begin
              state_r     <= DONE;
              mem_req_r   <= 1'b0;
              mem_we_r    <= 1'b0;
              done_r      <= 1'b1;
              final_ptr_r <= dec_r ? mem_addr_r : (mem_addr_r + STEP);
            end else begin
              k_r          <= k_r + CNT_W'(1);
              mem_addr_r   <= dec_r ? (mem_addr_r - STEP) : (mem_addr_r + STEP);
              reg_rd_idx_r <= dec_r ? (reg_rd_idx_r - REG_W'(1)) : (reg_rd_idx_r + REG_W'(1));
            end
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r    <= 1'b0;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign final_ptr   = final_ptr_r;
  assign reg_rd_idx  = reg_rd_idx_r;
  assign reg_wr_en   = reg_wr_en_r;
  assign reg_wr_idx  = reg_wr_idx_r;
  assign reg_wr_data = reg_wr_data_r;
  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = (mem_req_r && mem_we_r) ? reg_rd_data : '0;

endmodule

// File: tb/tb_blkmov_engine.sv
// Directed bench for blkmov_engine: table of block moves plus a reset-abort sequence.
module tb_blkmov_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic        decrement = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic [3:0]  first_reg = 4'h0;
  logic [3:0]  count = 4'h0;
  logic        busy, done;
  logic [31:0] final_ptr;
  logic [3:0]  reg_rd_idx;
  logic [31:0] reg_rd_data;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register file contents are a fixed function of the index
  assign reg_rd_data = 32'hC000_0000 | 32'(reg_rd_idx);

  blkmov_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .decrement(decrement),
    .base_addr(base_addr), .first_reg(first_reg), .count(count), .busy(busy), .done(done),
    .final_ptr(final_ptr), .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        st;
    logic        dec;
    logic [31:0] base;
    logic [3:0]  first;
    logic [3:0]  cnt;
    logic [31:0] dbase;
    int          stall_word;
    int          stall_len;
    int          exp_n;
    logic [31:0] exp_final;
    int          exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input vec_t v, input int j);
    if (v.dec) return v.base - 32'((j + 1) * 4);
    else       return v.base + 32'(j * 4);
  endfunction

  function automatic logic [3:0] exp_reg(input vec_t v, input int j);
    if (v.dec) return v.first + 4'(v.exp_n - 1 - j);
    else       return v.first + 4'(j);
  endfunction

  task automatic run_vec(input vec_t v);
    int       k = 0;
    int       stall = 0;
    logic     pend = 1'b0;
    int       pend_k = 0;
    logic     finished = 1'b0;
    @(negedge clk);
    start = 1'b1; is_store = v.st; decrement = v.dec;
    base_addr = v.base; first_reg = v.first; count = v.cnt;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 60 && !finished; cyc++) begin
      if (cyc > 1) @(negedge clk);
      mem_ack = 1'b0;
      if (pend) begin
        chk("wr_en", 64'(reg_wr_en), 64'd1);
        chk("wr_idx", 64'(reg_wr_idx), 64'(exp_reg(v, pend_k)));
        chk("wr_data", 64'(reg_wr_data), 64'(v.dbase + 32'(pend_k)));
        pend = 1'b0;
      end else begin
        chk("wr_en_quiet", 64'(reg_wr_en), 64'd0);
      end
      chk("busy", 64'(busy), 64'd1);
      if (done) begin
        chk("done_cycle", 64'(cyc), 64'(v.exp_done));
        chk("final_ptr", 64'(final_ptr), 64'(v.exp_final));
        chk("words", 64'(k), 64'(v.exp_n));
        chk("req_at_done", 64'(mem_req), 64'd0);
        finished = 1'b1;
      end else if (mem_req) begin
        chk("addr", 64'(mem_addr), 64'(exp_addr(v, k)));
        chk("rd_idx", 64'(reg_rd_idx), 64'(exp_reg(v, k)));
        chk("we", 64'(mem_we), 64'(v.st));
        if (v.st) chk("wdata", 64'(mem_wdata), 64'(32'hC000_0000 | 32'(exp_reg(v, k))));
        if (k == v.stall_word && stall < v.stall_len) begin
          stall++;
        end else begin
          mem_ack = 1'b1;
          mem_rdata = v.dbase + 32'(k);
          if (!v.st) begin
            pend = 1'b1;
            pend_k = k;
          end
          k++;
        end
      end else begin
        chk("req_missing", 64'(mem_req), 64'd1);
      end
    end
    if (!finished) chk("done_timeout", 64'(done), 64'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("done_after", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("req_after", 64'(mem_req), 64'd0);
    chk("wr_en_after", 64'(reg_wr_en), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_rd_idx"}, 64'(reg_rd_idx), 64'd0);
    chk({tag, "_wr_en"}, 64'(reg_wr_en), 64'd0);
    chk({tag, "_wr_idx"}, 64'(reg_wr_idx), 64'd0);
    chk({tag, "_wr_data"}, 64'(reg_wr_data), 64'd0);
    chk({tag, "_final"}, 64'(final_ptr), 64'd0);
  endtask

  initial begin
    //         st    dec   base           first cnt    dbase         sw  sl  N  final          done
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 4'd2,  4'd4,  32'h0000_00A0, -1, 0, 4, 32'h0000_0110, 5};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 4'd5,  4'd3,  32'h0,         -1, 0, 3, 32'h0000_01F4, 4};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0100, 4'd2,  4'd4,  32'h0000_00A0,  1, 3, 4, 32'h0000_0110, 8};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0040, 4'd9,  4'd0,  32'h0,         -1, 0, 0, 32'h0000_0040, 1};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFF8, 4'd14, 4'd12, 32'h0000_0050, -1, 0, 8, 32'h0000_0018, 9};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 4'd15, 4'd2,  32'h0,          0, 2, 2, 32'h0000_0008, 5};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0004, 4'd0,  4'd3,  32'h0000_0700,  2, 1, 3, 32'hFFFF_FFF8, 5};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset during a 6-word load after two words have been acknowledged
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; decrement = 1'b0;
    base_addr = 32'h0000_0300; first_reg = 4'd0; count = 4'd6;
    @(negedge clk);
    start = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_0011;
    @(negedge clk);
    chk("rst_seq_addr1", 64'(mem_addr), 64'h304);
    @(negedge clk);
    chk("rst_seq_wr_pending", 64'(reg_wr_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_wr_en", 64'(reg_wr_en), 64'd0);
      chk("abort_req", 64'(mem_req), 64'd0);
    end
    mem_ack = 1'b0;
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
